// File: rtl/arbitro_qos_pkg.sv
// rtl/arbitro_qos_pkg.sv - shared mode encodings for the QoS arbiter
// Purpose: mode enumeration used by the arbiter and its bench, plus the
//          decoder that maps the raw 2-bit request onto a mode.
// Contents: modo_e (REGULAR, PESADO, ARBITRADO), decode_modo().
package arbitro_qos_pkg;

  typedef enum logic [1:0] {
    REGULAR   = 2'b00,
    PESADO    = 2'b01,
    ARBITRADO = 2'b10
  } modo_e;

  // 2'b11 has no mode of its own and falls back to round robin.
  function automatic modo_e decode_modo(input logic [1:0] m);
    case (m)
      2'b01:   return PESADO;
      2'b10:   return ARBITRADO;
      default: return REGULAR;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_qos_buscador_rr.sv
// rtl/arbitro_qos_buscador_rr.sv - circular next-non-empty queue search
// Purpose: find the first non-empty queue scanning pointer+1, pointer+2, ...
//          wrapping round to pointer itself last.
// Ports: pointer   - scan origin (excluded until the final wrap position)
//        buf_empty - per-queue empty flags
//        index     - first non-empty queue found (pointer when none)
//        found     - at least one queue is non-empty
module buscador_rr #(
  parameter int N = 4
) (
  input  logic [$clog2(N)-1:0] pointer,
  input  logic [N-1:0]         buf_empty,
  output logic [$clog2(N)-1:0] index,
  output logic                 found
);

  localparam int S = $clog2(N);

  // Walk from the farthest candidate back to the nearest so the nearest
  // non-empty queue is the last assignment and therefore wins. N is a power
  // of two, so the S-bit add wraps modulo N and offset N lands on pointer.
  always_comb begin
    index = pointer;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (!buf_empty[pointer + S'(k)]) begin
        index = pointer + S'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_qos.sv
// rtl/arbitro_qos.sv - QoS queue arbiter with regular, weighted and table modes
// Purpose: grants one queue per cycle with a registered one-cycle latency.
// Ports: clk, rst (async, active-high), enb (0 freezes state, no grant)
//        modo           - requested mode, applied at burst boundaries
//        buf_empty      - per-queue empty flags
//        pesos          - per-queue burst weight, queue k at [k*W +: W]
//        pesosArbitraje - per-entry burst weight, entry i at [i*W +: W]
//        selecciones    - per-entry queue id, entry i at [i*S +: S]
//        selector       - granted queue
//        selector_enb   - grant valid
//        modo_activo    - mode applied to the current output
module arbitro_qos
  import arbitro_qos_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT     = 64,
  parameter int TABLE_SIZE     = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         enb,
  input  logic [1:0]                                   modo,
  input  logic [QUEUE_QUANTITY-1:0]                    buf_empty,
  input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0] pesos,
  input  logic [TABLE_SIZE*$clog2(MAX_WEIGHT)-1:0]     pesosArbitraje,
  input  logic [TABLE_SIZE*$clog2(QUEUE_QUANTITY)-1:0] selecciones,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]            selector,
  output logic                                         selector_enb,
  output logic [1:0]                                   modo_activo
);

  localparam int N  = QUEUE_QUANTITY;
  localparam int W  = $clog2(MAX_WEIGHT);
  localparam int T  = TABLE_SIZE;
  localparam int S  = $clog2(N);
  localparam int TW = $clog2(T);

  modo_e          modo_q, modo_n, eff;
  logic [S-1:0]   ptr_q, ptr_n, cur_q, cur_n, sel_q, sel_n;
  logic [W-1:0]   credit_q, credit_n, credit_eff;
  logic [TW-1:0]  tidx_q, tidx_n, tidx_p1;
  logic           grant_n, boundary, hit_found;
  logic [W-1:0]   w_cur, w_ent, w_nxt;
  logic [S-1:0]   q_ent, q_nxt, search_from, hit;

  // A zero weight still allows one grant per burst.
  function automatic logic [W-1:0] wsat(input logic [W-1:0] w);
    return (w == '0) ? W'(1) : w;
  endfunction

  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] i);
    return (i == TW'(T - 1)) ? '0 : i + TW'(1);
  endfunction

  buscador_rr #(.N(N)) u_buscador (
    .pointer   (search_from),
    .buf_empty (buf_empty),
    .index     (hit),
    .found     (hit_found)
  );

  always_comb begin
    tidx_p1 = tinc(tidx_q);
    w_cur   = wsat(pesos[int'(cur_q)*W +: W]);
    w_ent   = wsat(pesosArbitraje[int'(tidx_q)*W +: W]);
    w_nxt   = wsat(pesosArbitraje[int'(tidx_p1)*W +: W]);
    q_ent   = selecciones[int'(tidx_q)*S +: S];
    q_nxt   = selecciones[int'(tidx_p1)*S +: S];

    // Zero credit means no burst in progress, which is always a boundary.
    case (modo_q)
      PESADO:    boundary = (credit_q == '0) || buf_empty[cur_q] || (credit_q >= w_cur);
      ARBITRADO: boundary = (credit_q == '0) || buf_empty[q_ent] || (credit_q >= w_ent);
      default:   boundary = 1'b1;
    endcase

    eff         = boundary ? decode_modo(modo) : modo_q;
    credit_eff  = (eff != modo_q) ? '0 : credit_q;
    // Regular scans from the shared pointer, weighted from its burst queue.
    search_from = (eff == REGULAR) ? ptr_q : cur_q;

    modo_n   = eff;
    ptr_n    = ptr_q;
    cur_n    = cur_q;
    sel_n    = sel_q;
    grant_n  = 1'b0;
    credit_n = credit_eff;
    tidx_n   = tidx_q;

    if (!hit_found) begin
      credit_n = '0;
    end else begin
      case (eff)
        PESADO: begin
          grant_n = 1'b1;
          if (!buf_empty[cur_q] && (credit_eff < w_cur)) begin
            sel_n    = cur_q;
            ptr_n    = cur_q;
            credit_n = credit_eff + W'(1);
          end else begin
            sel_n    = hit;
            ptr_n    = hit;
            cur_n    = hit;
            credit_n = W'(1);
          end
        end
        ARBITRADO: begin
          if (buf_empty[q_ent]) begin
            tidx_n   = tidx_p1;
            credit_n = '0;
          end else if (credit_eff < w_ent) begin
            grant_n  = 1'b1;
            sel_n    = q_ent;
            credit_n = credit_eff + W'(1);
          end else if (!buf_empty[q_nxt]) begin
            // Exhausted entry hands over to the next one without a bubble.
            grant_n  = 1'b1;
            sel_n    = q_nxt;
            tidx_n   = tidx_p1;
            credit_n = (w_nxt != '0) ? W'(1) : '0;
          end else begin
            // Next entry is empty: skip past it in this same cycle.
            tidx_n   = tinc(tidx_p1);
            credit_n = '0;
          end
        end
        default: begin
          grant_n  = 1'b1;
          sel_n    = hit;
          ptr_n    = hit;
          cur_n    = hit;
          credit_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modo_q       <= REGULAR;
      ptr_q        <= S'(N - 1);
      cur_q        <= '0;
      credit_q     <= '0;
      tidx_q       <= '0;
      sel_q        <= '0;
      selector_enb <= 1'b0;
    end else if (enb) begin
      modo_q       <= modo_n;
      ptr_q        <= ptr_n;
      cur_q        <= cur_n;
      credit_q     <= credit_n;
      tidx_q       <= tidx_n;
      sel_q        <= sel_n;
      selector_enb <= grant_n;
    end else begin
      selector_enb <= 1'b0;
    end
  end

  assign selector    = sel_q;
  assign modo_activo = modo_q;

endmodule
